// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, types and helpers for the reg_file_8x8 register bank.
//   RF_WIDTH / RF_DEPTH : default register width and register count
//   sel_width()         : index width for a given depth (never narrower than 1 bit)
//   rf_data_t / rf_sel_t: data word and register-index types for the default geometry
package reg_file_pkg;

    localparam int unsigned RF_WIDTH = 8;
    localparam int unsigned RF_DEPTH = 8;

    function automatic int unsigned sel_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned RF_SEL_W = sel_width(RF_DEPTH);

    typedef logic [RF_WIDTH-1:0] rf_data_t;
    typedef logic [RF_SEL_W-1:0] rf_sel_t;

endpackage

// File: rtl/reg_cell.sv
// reg_cell: one WIDTH-bit storage register with asynchronous active-high clear and load enable.
//   clk    : rising-edge clock
//   clr    : asynchronous clear, active high; dominates any load
//   i_load : load i_d on the next rising clk edge
//   i_d    : data to load
//   o_q    : current register contents
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file_8x8.sv
// reg_file_8x8: DEPTH x WIDTH datapath register bank, one synchronous write port and one
// combinational read port, with an asynchronous active-high clear of every register.
//   clk  : rising-edge clock
//   clr  : asynchronous clear, active high; zeroes all registers and blocks writes
//   en   : write enable, sampled on rising clk
//   d    : write data
//   wsel : write register index
//   rsel : read register index
//   q    : read data, regs[rsel], zero-cycle latency
// Build option: define REGFILE_WRITE_BYPASS_EN to forward d onto q when a write targets the
// register being read (write-through). Without it reads are read-before-write.
module reg_file_8x8
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned DEPTH = RF_DEPTH,
    parameter int unsigned SEL_W = sel_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] wsel,
    input  logic [SEL_W-1:0] rsel,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_regs [DEPTH];
    logic [WIDTH-1:0] w_rd;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        // Write decoder: exactly one cell sees a load when en is high.
        assign w_load[i] = en & (wsel == SEL_W'(i));

        reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk    (clk),
            .clr    (clr),
            .i_load (w_load[i]),
            .i_d    (d),
            .o_q    (w_regs[i])
        );
    end

    assign w_rd = w_regs[rsel];

    always_comb begin
        q = w_rd;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (en && (wsel == rsel)) begin
            q = d;
        end
`endif
        // Cells are already zero under clr; this keeps the forwarding path from leaking d.
        if (clr) begin
            q = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_8x8.sv
module tb_reg_file_8x8;

    logic       clk;
    logic       clr;
    logic       en;
    logic [7:0] d;
    logic [2:0] wsel;
    logic [2:0] rsel;
    logic [7:0] q;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of register contents.
    logic [7:0] mem [8];

    reg_file_8x8 u_dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .d    (d),
        .wsel (wsel),
        .rsel (rsel),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_q();
        if (clr) return 8'h00;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (en && wsel == rsel) return d;
`endif
        return mem[rsel];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    endtask

    // One rising edge, applying the write to the model, then settle.
    task automatic tick();
        @(posedge clk);
        if (!clr && en) mem[wsel] = d;
        #1;
    endtask

    task automatic wr(input logic [2:0] w, input logic [7:0] v);
        @(negedge clk);
        en = 1'b1;
        wsel = w;
        d = v;
        tick();
        en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] s, input logic [7:0] exp);
        rsel = s;
        #1;
        check(tag, q, exp);
    endtask

    initial begin
        clr = 1'b1;
        en = 1'b0;
        d = 8'h00;
        wsel = 3'd0;
        rsel = 3'd0;
        model_clear();

        // Reset, released between edges.
        #12;
        clr = 1'b0;
        for (int i = 0; i < 8; i++) rd("reset_sweep", 3'(i), 8'h00);

        // Basic write/read.
        wr(3'd6, 8'h22);
        wr(3'd3, 8'h91);
        rd("rd_r6", 3'd6, 8'h22);
        rd("rd_r3", 3'd3, 8'h91);
        rd("rd_r0", 3'd0, 8'h00);

        // Enable gating.
        @(negedge clk);
        en = 1'b0;
        wsel = 3'd0;
        d = 8'h00;
        tick();
        tick();
        d = 8'hFF;
        tick();
        tick();
        rd("gate_r0", 3'd0, 8'h00);
        rd("gate_r6", 3'd6, 8'h22);

        // Async clear between edges.
        @(negedge clk);
        rsel = 3'd6;
        #1;
        check("pre_clr_r6", q, 8'h22);
        clr = 1'b1;
        #1;
        check("clr_async", q, 8'h00);
        clr = 1'b0;
        model_clear();
        rd("post_clr_r6", 3'd6, 8'h00);
        rd("post_clr_r3", 3'd3, 8'h00);

        // Write attempted while clr is held: clear wins.
        @(negedge clk);
        clr = 1'b1;
        en = 1'b1;
        wsel = 3'd2;
        d = 8'h77;
        tick();
        @(negedge clk);
        en = 1'b0;
        clr = 1'b0;
        rd("clr_blocks_wr", 3'd2, 8'h00);

        // Same-index read/write.
        @(negedge clk);
        rsel = 3'd5;
        wsel = 3'd5;
        d = 8'hA5;
        en = 1'b1;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("same_idx_pre", q, 8'hA5);
`else
        check("same_idx_pre", q, 8'h00);
`endif
        tick();
        check("same_idx_post", q, 8'hA5);
        en = 1'b0;

        // Exhaustive walk for aliasing.
        for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) rd("walk", 3'(i), 8'h10 + 8'(i));

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            wsel = 3'($urandom_range(0, 7));
            rsel = ($urandom_range(0, 3) == 0) ? wsel : 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                clr = 1'b1;
                #1;
                check("rnd_clr", q, 8'h00);
                model_clear();
                clr = 1'b0;
            end
            #1;
            check("rnd_pre", q, model_q());
            tick();
            check("rnd_post", q, model_q());
            rsel = 3'($urandom_range(0, 7));
            #1;
            check("rnd_reread", q, model_q());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
